// File: rtl/odev_uart_tx_if.sv
// Bundle of the CPU-side write strobe/data and the serial/status outputs of
// the odev0 UART transmitter. The transmitter uses the slave view; the
// driving side (CPU decode or a bench) uses the master view.
interface odev_uart_tx_if;
  logic       wr_bar;
  logic [7:0] din;
  logic       ovr_clr;
  logic       txd;
  logic       busy;
  logic       full;
  logic       empty;
  logic       ovr;
  logic [7:0] status;

  modport master (
    output wr_bar, din, ovr_clr,
    input  txd, busy, full, empty, ovr, status
  );

  modport slave (
    input  wr_bar, din, ovr_clr,
    output txd, busy, full, empty, ovr, status
  );
endinterface

// File: rtl/odev_uart_tx.sv
// odev0 serial transmitter: a small byte FIFO fed by the CPU output-device
// write strobe, drained by an async serializer (8N1, or 8E1 when the
// ODEV_UART_PARITY_EN macro is defined). All outputs come from flops.
module odev_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input logic             clk,
  input logic             rst,
  odev_uart_tx_if.slave   bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]   CNT_LOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

`ifdef ODEV_UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_PARITY = 3'd4
  } state_t;

  // Even parity over the data byte, latched when the byte is popped.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3
  } state_t;
`endif

  state_t        state_r, state_s;
  logic [15:0]   cnt_r, cnt_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic [7:0]    shift_r, shift_s;
  logic          txd_r, txd_s;
  logic          busy_r, full_r, empty_r, ovr_r;
  logic [LW-1:0] level_r, level_s;
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic          push_s, pop_s, drop_s;
  logic [3:0]    level4_s;
`ifdef ODEV_UART_PARITY_EN
  logic          parity_r, parity_s;
`endif

  // Serializer next-state: baud countdown, bit stepping, and FIFO pop decision.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    pop_s     = 1'b0;
`ifdef ODEV_UART_PARITY_EN
    parity_s  = parity_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (!empty_r) begin
          pop_s   = 1'b1;
          state_s = S_START;
          cnt_s   = CNT_LOAD;
          shift_s = mem_r[rd_ptr_r];
`ifdef ODEV_UART_PARITY_EN
          parity_s = even_parity(mem_r[rd_ptr_r]);
`endif
        end else begin
          cnt_s = 16'd0;
        end
      end
      S_START: begin
        if (cnt_r == 16'd0) begin
          state_s   = S_DATA;
          cnt_s     = CNT_LOAD;
          bit_idx_s = 3'd0;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_r == 16'd0) begin
          cnt_s     = CNT_LOAD;
          shift_s   = {1'b0, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
`ifdef ODEV_UART_PARITY_EN
            state_s = S_PARITY;
`else
            state_s = S_STOP;
`endif
          end else begin
            state_s = S_DATA;
          end
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
`ifdef ODEV_UART_PARITY_EN
      S_PARITY: begin
        if (cnt_r == 16'd0) begin
          state_s = S_STOP;
          cnt_s   = CNT_LOAD;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_r == 16'd0) begin
          // Back-to-back frames: a queued byte goes straight into START.
          if (!empty_r) begin
            pop_s   = 1'b1;
            state_s = S_START;
            cnt_s   = CNT_LOAD;
            shift_s = mem_r[rd_ptr_r];
`ifdef ODEV_UART_PARITY_EN
            parity_s = even_parity(mem_r[rd_ptr_r]);
`endif
          end else begin
            state_s = S_IDLE;
            cnt_s   = 16'd0;
          end
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 16'd0;
      end
    endcase
  end

  // Line level for the state being entered, so txd can be registered.
  always_comb begin
    txd_s = 1'b1;
    case (state_s)
      S_IDLE:   txd_s = 1'b1;
      S_START:  txd_s = 1'b0;
      S_DATA:   txd_s = shift_s[0];
`ifdef ODEV_UART_PARITY_EN
      S_PARITY: txd_s = parity_s;
`endif
      S_STOP:   txd_s = 1'b1;
      default:  txd_s = 1'b1;
    endcase
  end

  // FIFO accounting: a write into a full FIFO still lands if a pop frees a slot this edge.
  always_comb begin
    push_s  = (!bus.wr_bar) && ((!full_r) || pop_s);
    drop_s  = (!bus.wr_bar) && full_r && (!pop_s);
    level_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_s = level_r + LVL_ONE;
      2'b01:   level_s = level_r - LVL_ONE;
      default: level_s = level_r;
    endcase
  end

  // Control/status registers with synchronous reset; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      ovr_r     <= 1'b0;
      level_r   <= LW'(0);
      wr_ptr_r  <= PW'(0);
      rd_ptr_r  <= PW'(0);
`ifdef ODEV_UART_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      txd_r     <= txd_s;
      busy_r    <= (state_s != S_IDLE);
      full_r    <= (level_s == LVL_FULL);
      empty_r   <= (level_s == LW'(0));
      level_r   <= level_s;
`ifdef ODEV_UART_PARITY_EN
      parity_r  <= parity_s;
`endif
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      // A drop on the same edge as a clear leaves the flag set.
      if (drop_s) begin
        ovr_r <= 1'b1;
      end else if (bus.ovr_clr) begin
        ovr_r <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.din;
    end
  end

  assign level4_s   = 4'(level_r);
  assign bus.txd    = txd_r;
  assign bus.busy   = busy_r;
  assign bus.full   = full_r;
  assign bus.empty  = empty_r;
  assign bus.ovr    = ovr_r;
  assign bus.status = {busy_r, full_r, empty_r, ovr_r, level4_s};

endmodule

// File: tb/tb_odev_uart_tx.sv
// Bench for odev_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4). Written bytes go
// into a scoreboard queue; a serial receiver decodes txd and pops/compares.
// Build with ODEV_UART_PARITY_EN defined to exercise the parity frame.
module tb_odev_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef ODEV_UART_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  typedef struct {
    int         k;
    logic [7:0] start;
    int         n_acc;
    logic [7:0] exp_status;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [7:0] exp_q [$];
  vec_t vecs [8];

  odev_uart_tx_if bus_if ();

  odev_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input int bound);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!bus_if.busy && bus_if.empty) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle", {31'd0, ok}, 32'd1);
  endtask

  task automatic write_burst(input logic [7:0] start, input int k, input int n_acc);
    logic [7:0] b;
    for (int i = 0; i < k; i++) begin
      b = start + 8'(i);
      bus_if.wr_bar = 1'b0;
      bus_if.din    = b;
      if (i < n_acc) exp_q.push_back(b);
      @(negedge clk);
    end
    bus_if.wr_bar = 1'b1;
  endtask

  // Serial receiver: detects a start bit, samples each bit once, checks framing.
  initial begin
    logic [7:0] got;
    logic [7:0] e;
    logic       aborted;
    logic       par;
    forever begin
      @(negedge clk);
      if (!rst && bus_if.txd === 1'b0) begin
        got = 8'd0;
        par = 1'b0;
        aborted = 1'b0;
        for (int c = 1; c < FRAME; c++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (c == 2) check("mon_start_bit", {31'd0, bus_if.txd}, 32'd0);
          if (c >= CPB && c < 9 * CPB && (c % CPB) == 1) got[(c - CPB) / CPB] = bus_if.txd;
          if (c == 9 * CPB + 1) par = bus_if.txd;
          if (c == FRAME - CPB + 1) check("mon_stop_bit", {31'd0, bus_if.txd}, 32'd1);
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL mon_unexpected_frame: got 0x%0h expected no frame", got);
          end else begin
            e = exp_q.pop_front();
            check("mon_data", {24'd0, got}, {24'd0, e});
`ifdef ODEV_UART_PARITY_EN
            check("mon_parity", {31'd0, par}, {31'd0, ^e});
`endif
          end
        end
      end
    end
  end

  // Absolute time limit so a stuck design still terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a5;
    logic       exp_bit;
    int         cyc;
    int         exp_cyc;

    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{k: 1, start: 8'h30, n_acc: 1, exp_status: 8'h01};
    vecs[1] = '{k: 2, start: 8'h40, n_acc: 2, exp_status: 8'h81};
    vecs[2] = '{k: 3, start: 8'h50, n_acc: 3, exp_status: 8'h82};
    vecs[3] = '{k: 4, start: 8'hF0, n_acc: 4, exp_status: 8'h83};
    vecs[4] = '{k: 5, start: 8'h01, n_acc: 5, exp_status: 8'hC4};
    vecs[5] = '{k: 6, start: 8'h01, n_acc: 5, exp_status: 8'hD4};
    vecs[6] = '{k: 1, start: 8'h07, n_acc: 1, exp_status: 8'h01};
    vecs[7] = '{k: 1, start: 8'h03, n_acc: 1, exp_status: 8'h01};

    rst = 1'b1;
    bus_if.wr_bar  = 1'b1;
    bus_if.din     = 8'd0;
    bus_if.ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_status", {24'd0, bus_if.status}, 32'h20);
    check("reset_txd", {31'd0, bus_if.txd}, 32'd1);

    // Exact waveform of a single 0xA5 frame.
    wait_idle(200);
    a5 = 8'hA5;
    bus_if.wr_bar = 1'b0;
    bus_if.din    = a5;
    exp_q.push_back(a5);
    @(negedge clk);
    bus_if.wr_bar = 1'b1;
    check("a5_pre_pop_status", {24'd0, bus_if.status}, 32'h01);
    check("a5_pre_pop_txd", {31'd0, bus_if.txd}, 32'd1);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (c < CPB) exp_bit = 1'b0;
      else if (c < 9 * CPB) exp_bit = a5[(c - CPB) / CPB];
      else if (c < FRAME - CPB) exp_bit = ^a5;
      else exp_bit = 1'b1;
      check("a5_txd", {31'd0, bus_if.txd}, {31'd0, exp_bit});
      check("a5_busy", {31'd0, bus_if.busy}, 32'd1);
    end
    @(negedge clk);
    check("a5_busy_end", {31'd0, bus_if.busy}, 32'd0);

    // Table: bursts of consecutive writes from idle.
    for (int v = 0; v < 8; v++) begin
      wait_idle(2000);
      write_burst(vecs[v].start, vecs[v].k, vecs[v].n_acc);
      check("burst_status", {24'd0, bus_if.status}, {24'd0, vecs[v].exp_status});
      exp_cyc = 2 + FRAME * vecs[v].n_acc - vecs[v].k;
      cyc = 0;
      for (int c = 1; c <= exp_cyc + 20; c++) begin
        @(negedge clk);
        cyc = c;
        if (!bus_if.busy) break;
      end
      check("burst_busy_cycles", cyc, exp_cyc);
      if (vecs[v].k > vecs[v].n_acc) begin
        check("burst_ovr_sticky", {24'd0, bus_if.status}, 32'h30);
        bus_if.ovr_clr = 1'b1;
        @(negedge clk);
        bus_if.ovr_clr = 1'b0;
      end
      check("burst_drained_status", {24'd0, bus_if.status}, 32'h20);
    end

    // Write into a full FIFO on the same edge as a pop.
    wait_idle(200);
    write_burst(8'h11, 5, 5);
    check("pp_full", {24'd0, bus_if.status}, 32'hC4);
    repeat (FRAME - 4) @(negedge clk);
    check("pp_before", {24'd0, bus_if.status}, 32'hC4);
    bus_if.wr_bar = 1'b0;
    bus_if.din    = 8'h16;
    exp_q.push_back(8'h16);
    @(negedge clk);
    bus_if.wr_bar = 1'b1;
    check("pp_after", {24'd0, bus_if.status}, 32'hC4);
    wait_idle(2000);
    check("pp_no_ovr", {31'd0, bus_if.ovr}, 32'd0);

    // Reset in the middle of a frame with bytes still queued.
    write_burst(8'h90, 3, 3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_mid_txd", {31'd0, bus_if.txd}, 32'd1);
    check("rst_mid_busy", {31'd0, bus_if.busy}, 32'd0);
    check("rst_mid_empty", {31'd0, bus_if.empty}, 32'd1);
    check("rst_mid_status", {24'd0, bus_if.status}, 32'h20);
    @(negedge clk);
    check("rst_after_status", {24'd0, bus_if.status}, 32'h20);
    check("rst_after_txd", {31'd0, bus_if.txd}, 32'd1);

    // One frame after reset to show normal operation resumes.
    write_burst(8'h5A, 1, 1);
    wait_idle(200);
    repeat (2) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
